serial_shift_out: RTL

- Parallel-to-serial counterpart of the board's button-driven LED shift register.
- Captures a WIDTH-bit word on a load-key press, then shifts it out one bit per step. A step is either a step-key press or an internal timer tick.
- Drives the remaining word onto the LEDs plus serial/strobe/status outputs.
- Sits directly between board keys/switches and LEDs or a GPIO pin.

---
 rtl/serial_shift_out_pkg.sv | 16 +
 rtl/serial_shift_out_if.sv | 34 +++
 rtl/key_edge_detect.sv | 30 +++
 rtl/serial_shift_out.sv | 111 +++++++++++
 4 files changed

// File: rtl/serial_shift_out_pkg.sv
// rtl/serial_shift_out_pkg.sv - shared types and constants for the serial shift-out block
// Purpose: FSM state type, shift direction encodings and the default step timer period.
package serial_shift_out_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // One automatic step per second with a 50 MHz board clock.
  localparam int DEFAULT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/serial_shift_out_if.sv
// rtl/serial_shift_out_if.sv - key/switch inputs and serial/LED outputs of serial_shift_out
// Purpose: bundles the board-facing signals of the shifter.
// Ports (signals):
//   data_in, load_button, step_button, auto_mode, dir_sel  - from keys/switches
//   serial_out, bit_strobe, busy, done, bit_count, values   - to LEDs / GPIO
// Modports: master = board side (drives keys), slave = shifter.
interface serial_shift_out_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);

  logic [WIDTH-1:0] data_in;
  logic             load_button;
  logic             step_button;
  logic             auto_mode;
  logic             dir_sel;
  logic             serial_out;
  logic             bit_strobe;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_count;
  logic [WIDTH-1:0] values;

  modport master (
    output data_in, load_button, step_button, auto_mode, dir_sel,
    input  serial_out, bit_strobe, busy, done, bit_count, values
  );

  modport slave (
    input  data_in, load_button, step_button, auto_mode, dir_sel,
    output serial_out, bit_strobe, busy, done, bit_count, values
  );

endinterface

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - two-flop key synchronizer with rising-edge pulse
// Purpose: brings an asynchronous key into the clk domain and emits one pulse per press.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   i_key  - raw key level
//   o_push - high for one cycle after each 0->1 key transition
module key_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_push
);

  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= i_key;
      r_sync_d <= r_sync;
    end
  end

  assign o_push = r_sync & ~r_sync_d;

endmodule

// File: rtl/serial_shift_out.sv
// rtl/serial_shift_out.sv - parallel-to-serial shifter driven by keys or a step timer
// Purpose: loads a word on a load-key press and emits it one bit per step
//          (step key or timer tick), MSB or LSB first.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - serial_shift_out_if.slave (keys/switches in, serial/LED outputs)
module serial_shift_out
  import serial_shift_out_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  serial_shift_out_if.slave   bus
);

  localparam int             TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

  logic w_load_push;
  logic w_step_push;
  logic w_tick;
  logic w_step;

  state_t           r_state;
  logic [WIDTH-1:0] r_values;
  logic [CNT_W-1:0] r_bit_count;
  logic [TW-1:0]    r_tick_cnt;
  logic             r_dir;
  logic             r_serial;
  logic             r_strobe;
  logic             r_busy;
  logic             r_done;

  key_edge_detect u_load_key (
    .clk    (clk),
    .rst_n  (reset),
    .i_key  (bus.load_button),
    .o_push (w_load_push)
  );

  key_edge_detect u_step_key (
    .clk    (clk),
    .rst_n  (reset),
    .i_key  (bus.step_button),
    .o_push (w_step_push)
  );

  assign w_tick = (r_state == SHIFT) && bus.auto_mode && (r_tick_cnt == TICK_LAST);
  assign w_step = bus.auto_mode ? w_tick : w_step_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_values    <= '0;
      r_bit_count <= '0;
      r_tick_cnt  <= '0;
      r_dir       <= DIR_MSB_FIRST;
      r_serial    <= 1'b0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;

      // Timer only runs while shifting automatically; leaving auto mode drops the partial count.
      if (r_state == SHIFT && bus.auto_mode) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      end else begin
        r_tick_cnt <= '0;
      end

      // A load always wins, even over a step landing in the same cycle.
      if (w_load_push) begin
        r_values    <= bus.data_in;
        r_bit_count <= CNT_W'(WIDTH);
        r_dir       <= bus.dir_sel;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_tick_cnt  <= '0;
        r_state     <= SHIFT;
      end else if (r_state == SHIFT && w_step) begin
        if (r_dir == DIR_LSB_FIRST) begin
          r_serial <= r_values[0];
          r_values <= r_values >> 1;
        end else begin
          r_serial <= r_values[WIDTH-1];
          r_values <= r_values << 1;
        end
        r_strobe    <= 1'b1;
        r_bit_count <= r_bit_count - CNT_W'(1);
        if (r_bit_count == CNT_W'(1)) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      end
    end
  end

  assign bus.serial_out = r_serial;
  assign bus.bit_strobe = r_strobe;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.bit_count  = r_bit_count;
  assign bus.values     = r_values;

endmodule
